// File: rtl/l2_cache_miss_queue.sv
// l2_cache_miss_queue: in-order L2 miss buffer. It issues one memory read per
// non-duplicate miss, collects fills in request order and hands each completed
// miss back to the L2 pipeline through a single restart register.
module l2_cache_miss_queue #(
  parameter int QUEUE_SIZE       = 8,
  parameter int LINE_INDEX_WIDTH = 26,
  parameter int LINE_WIDTH       = 512
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enq_valid,
  input  logic [LINE_INDEX_WIDTH-1:0] enq_addr,
  input  logic                        enq_duplicate,
  output logic                        enq_ready,
  output logic                        mem_req_valid,
  output logic [LINE_INDEX_WIDTH-1:0] mem_req_addr,
  input  logic                        mem_req_ready,
  input  logic                        mem_resp_valid,
  input  logic [LINE_WIDTH-1:0]       mem_resp_data,
  output logic                        mem_resp_ready,
  output logic                        restart_valid,
  output logic [LINE_INDEX_WIDTH-1:0] restart_addr,
  output logic [LINE_WIDTH-1:0]       restart_data,
  output logic                        restart_is_fill,
  input  logic                        restart_ack
);

  localparam int PW = $clog2(QUEUE_SIZE);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_SIZE);

  logic [LINE_INDEX_WIDTH-1:0] addr_mem [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0]       dup_mem;

  logic [PW-1:0] tail;
  logic [PW-1:0] issue;
  logic [PW-1:0] head;
  logic [CW-1:0] count;
  // Entries between head and issue. With a full queue tail, issue and head can
  // all be equal whether nothing or everything has been issued, so this count
  // is what tells the two cases apart.
  logic [CW-1:0] issued_count;

  logic enq_fire;
  logic issue_pending;
  logic issue_is_dup;
  logic issue_adv;
  logic head_issued;
  logic head_is_dup;
  logic restart_free;
  logic complete;

  assign enq_ready     = (count != FULL_COUNT);
  assign enq_fire      = enq_valid && enq_ready;

  assign issue_pending = (issued_count != count);
  assign issue_is_dup  = dup_mem[issue];
  assign mem_req_valid = issue_pending && !issue_is_dup;
  assign mem_req_addr  = addr_mem[issue];
  assign issue_adv     = issue_pending && (issue_is_dup || mem_req_ready);

  assign head_issued    = (issued_count != '0);
  assign head_is_dup    = dup_mem[head];
  assign restart_free   = !restart_valid || restart_ack;
  assign mem_resp_ready = head_issued && !head_is_dup && restart_free;
  assign complete       = head_issued && restart_free && (head_is_dup || mem_resp_valid);

  // Entry storage is written at the tail; occupied slots are never rewritten,
  // which keeps mem_req_addr stable while a request waits for acceptance.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      addr_mem[tail] <= enq_addr;
      dup_mem[tail]  <= enq_duplicate;
    end
  end

  // Pointer and occupancy bookkeeping for enqueue, issue and completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tail         <= '0;
      issue        <= '0;
      head         <= '0;
      count        <= '0;
      issued_count <= '0;
    end else begin
      if (enq_fire) begin
        tail <= tail + PW'(1);
      end
      if (issue_adv) begin
        issue <= issue + PW'(1);
      end
      if (complete) begin
        head <= head + PW'(1);
      end
      count        <= count + CW'(enq_fire) - CW'(complete);
      issued_count <= issued_count + CW'(issue_adv) - CW'(complete);
    end
  end

  // Restart register: loads on completion, clears on ack unless reloaded.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      restart_valid   <= 1'b0;
      restart_is_fill <= 1'b0;
      restart_addr    <= '0;
      restart_data    <= '0;
    end else if (complete) begin
      restart_valid   <= 1'b1;
      restart_addr    <= addr_mem[head];
      restart_is_fill <= !head_is_dup;
      if (!head_is_dup) begin
        restart_data <= mem_resp_data;
      end
    end else if (restart_ack) begin
      restart_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_l2_cache_miss_queue.sv
// tb_l2_cache_miss_queue: directed bench for the L2 miss queue. A queue-based
// model of expected requests and restarts is checked on every cycle, and a few
// literal expectations pin the model to hand-computed values.
module tb_l2_cache_miss_queue;

  localparam int LIW = 26;
  localparam int LW  = 512;

  logic           clk;
  logic           reset_n;
  logic           enq_valid;
  logic [LIW-1:0] enq_addr;
  logic           enq_duplicate;
  logic           enq_ready;
  logic           mem_req_valid;
  logic [LIW-1:0] mem_req_addr;
  logic           mem_req_ready;
  logic           mem_resp_valid;
  logic [LW-1:0]  mem_resp_data;
  logic           mem_resp_ready;
  logic           restart_valid;
  logic [LIW-1:0] restart_addr;
  logic [LW-1:0]  restart_data;
  logic           restart_is_fill;
  logic           restart_ack;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Memory and pipeline behaviour knobs: 0 = hold low, 1 = hold high, 2 = random.
  int req_mode = 1;
  int resp_mode = 1;
  int ack_mode = 1;
  int resp_delay = 2;

  // Expected-behaviour model and the memory's own outstanding-request queue.
  logic [LIW-1:0] exp_req [$];
  logic [LIW:0]   exp_rst [$];
  logic [LIW-1:0] mem_q [$];
  int             mem_t [$];
  logic [LIW:0]   rst_log [$];
  logic [31:0]    rst_w0 [$];
  int             req_total = 0;

  logic           prev_req_stall = 1'b0;
  logic [LIW-1:0] prev_req_addr = '0;
  logic           prev_rst_stall = 1'b0;
  logic [LIW-1:0] prev_rst_addr = '0;
  logic           prev_rst_fill = 1'b0;
  logic [LW-1:0]  prev_rst_data = '0;

  l2_cache_miss_queue dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enq_valid       (enq_valid),
    .enq_addr        (enq_addr),
    .enq_duplicate   (enq_duplicate),
    .enq_ready       (enq_ready),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_req_ready   (mem_req_ready),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .mem_resp_ready  (mem_resp_ready),
    .restart_valid   (restart_valid),
    .restart_addr    (restart_addr),
    .restart_data    (restart_data),
    .restart_is_fill (restart_is_fill),
    .restart_ack     (restart_ack)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Fill data is a recognisable function of the line index.
  function automatic logic [LW-1:0] fill_of(input logic [LIW-1:0] a);
    logic [31:0] w;
    w = {6'h2A, a};
    return {16{w}};
  endfunction

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one miss and hold it until the queue accepts it (bounded).
  task automatic applyStimulus(input logic [LIW-1:0] a, input logic d);
    bit ok;
    ok = 1'b0;
    enq_valid     = 1'b1;
    enq_addr      = a;
    enq_duplicate = d;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (enq_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("enq_accepted", LW'(ok), LW'(1));
    step();
    enq_valid = 1'b0;
  endtask

  // Wait until every expected request and restart has been seen (bounded).
  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (exp_req.size() == 0 && exp_rst.size() == 0 && mem_q.size() == 0 && !restart_valid) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drain_complete", LW'(done), LW'(1));
    step();
  endtask

  // Memory and restart-consumer driver, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    mem_req_ready = (req_mode == 1) || (req_mode == 2 && $urandom_range(0, 1) == 1);
    if (mem_q.size() > 0 && cyc >= mem_t[0] && (resp_mode == 1 || $urandom_range(0, 1) == 1)) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = fill_of(mem_q[0]);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
    restart_ack = (ack_mode == 1) || (ack_mode == 2 && $urandom_range(0, 1) == 1);
  end

  // Per-cycle compare against the model, sampled on the falling edge; what is
  // seen here is what handshakes on the next rising edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_req.delete();
      exp_rst.delete();
      mem_q.delete();
      mem_t.delete();
      prev_req_stall = 1'b0;
      prev_rst_stall = 1'b0;
    end else begin
      if (enq_valid && enq_ready) begin
        if (!enq_duplicate) exp_req.push_back(enq_addr);
        exp_rst.push_back({enq_addr, !enq_duplicate});
      end
      if (prev_req_stall) begin
        checkOutput("req_hold_valid", LW'(mem_req_valid), LW'(1));
        checkOutput("req_hold_addr", LW'(mem_req_addr), LW'(prev_req_addr));
      end
      if (mem_req_valid && mem_req_ready) begin
        checkOutput("req_expected", LW'(exp_req.size() > 0), LW'(1));
        if (exp_req.size() > 0) begin
          checkOutput("req_addr_order", LW'(mem_req_addr), LW'(exp_req[0]));
          void'(exp_req.pop_front());
        end
        mem_q.push_back(mem_req_addr);
        mem_t.push_back(cyc + resp_delay);
        req_total++;
      end
      prev_req_stall = mem_req_valid && !mem_req_ready;
      prev_req_addr  = mem_req_addr;
      if (mem_resp_valid && mem_resp_ready && mem_q.size() > 0) begin
        void'(mem_q.pop_front());
        void'(mem_t.pop_front());
      end
      if (prev_rst_stall) begin
        checkOutput("restart_hold_valid", LW'(restart_valid), LW'(1));
        checkOutput("restart_hold_addr", LW'(restart_addr), LW'(prev_rst_addr));
        checkOutput("restart_hold_fill", LW'(restart_is_fill), LW'(prev_rst_fill));
        if (prev_rst_fill) checkOutput("restart_hold_data", restart_data, prev_rst_data);
      end
      if (restart_valid && !restart_ack) begin
        checkOutput("resp_blocked_by_restart", LW'(mem_resp_ready), LW'(0));
      end
      if (restart_valid && restart_ack) begin
        checkOutput("restart_expected", LW'(exp_rst.size() > 0), LW'(1));
        if (exp_rst.size() > 0) begin
          checkOutput("restart_addr_order", LW'(restart_addr), LW'(exp_rst[0][LIW:1]));
          checkOutput("restart_is_fill", LW'(restart_is_fill), LW'(exp_rst[0][0]));
          if (exp_rst[0][0]) checkOutput("restart_data", restart_data, fill_of(exp_rst[0][LIW:1]));
          void'(exp_rst.pop_front());
        end
        rst_log.push_back({restart_addr, restart_is_fill});
        rst_w0.push_back(restart_data[31:0]);
      end
      prev_rst_stall = restart_valid && !restart_ack;
      prev_rst_addr  = restart_addr;
      prev_rst_fill  = restart_is_fill;
      prev_rst_data  = restart_data;
    end
  end

  // Safety net in case a wait escapes its bound.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int base;
    int req0;
    bit seen;
    reset_n        = 1'b0;
    enq_valid      = 1'b0;
    enq_addr       = '0;
    enq_duplicate  = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    restart_ack    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_enq_ready", LW'(enq_ready), LW'(1));
    checkOutput("rst_mem_req_valid", LW'(mem_req_valid), LW'(0));
    checkOutput("rst_mem_resp_ready", LW'(mem_resp_ready), LW'(0));
    checkOutput("rst_restart_valid", LW'(restart_valid), LW'(0));
    checkOutput("rst_restart_is_fill", LW'(restart_is_fill), LW'(0));
    step();

    // Single miss: request visible the cycle after enqueue, one fill restart.
    $display("[TB] single miss");
    req_mode = 1; resp_mode = 1; ack_mode = 1; resp_delay = 2;
    req0 = req_total; base = rst_log.size();
    applyStimulus(26'h100, 1'b0);
    @(negedge clk);
    checkOutput("single_req_valid", LW'(mem_req_valid), LW'(1));
    checkOutput("single_req_addr", LW'(mem_req_addr), LW'(26'h100));
    wait_idle(200);
    checkOutput("single_req_count", LW'(req_total - req0), LW'(1));
    checkOutput("single_restart_count", LW'(rst_log.size() - base), LW'(1));
    if (rst_log.size() > base) begin
      checkOutput("single_restart_entry", LW'(rst_log[base]), LW'({26'h100, 1'b1}));
      checkOutput("single_restart_word0", LW'(rst_w0[base]), LW'(32'hA800_0100));
    end
    checkOutput("single_empty_ready", LW'(enq_ready), LW'(1));

    // Duplicate ordering: one memory read, fill restart before the duplicate.
    $display("[TB] duplicate ordering");
    resp_delay = 10;
    req0 = req_total; base = rst_log.size();
    applyStimulus(26'h200, 1'b0);
    applyStimulus(26'h200, 1'b1);
    wait_idle(300);
    checkOutput("dup_req_count", LW'(req_total - req0), LW'(1));
    checkOutput("dup_restart_count", LW'(rst_log.size() - base), LW'(2));
    if (rst_log.size() > base + 1) begin
      checkOutput("dup_first_is_fill", LW'(rst_log[base]), LW'({26'h200, 1'b1}));
      checkOutput("dup_second_is_dup", LW'(rst_log[base+1]), LW'({26'h200, 1'b0}));
    end

    // Full queue with memory stalled, then release and drain.
    $display("[TB] full and backpressure");
    req_mode = 0; resp_delay = 1;
    step();
    base = rst_log.size();
    for (int i = 0; i < 8; i++) applyStimulus(LIW'(26'h300 + i), 1'b0);
    @(negedge clk);
    checkOutput("full_enq_ready", LW'(enq_ready), LW'(0));
    checkOutput("full_req_waiting", LW'(mem_req_valid), LW'(1));
    checkOutput("full_req_first_addr", LW'(mem_req_addr), LW'(26'h300));
    step();
    enq_valid = 1'b1; enq_addr = 26'h3FF; enq_duplicate = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("ninth_not_accepted", LW'(enq_ready), LW'(0));
      step();
    end
    enq_valid = 1'b0;
    req_mode = 1;
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (restart_valid) begin
        checkOutput("ready_after_first_completion", LW'(enq_ready), LW'(1));
        seen = 1'b1;
        break;
      end
      checkOutput("still_full", LW'(enq_ready), LW'(0));
    end
    checkOutput("first_restart_seen", LW'(seen), LW'(1));
    step();
    wait_idle(300);
    checkOutput("full_restart_count", LW'(rst_log.size() - base), LW'(8));
    if (rst_log.size() > base + 7) begin
      checkOutput("full_last_restart", LW'(rst_log[base+7]), LW'({26'h307, 1'b1}));
    end

    // Pointer wrap: 20 misses, every fourth a duplicate, random stalls.
    $display("[TB] pointer wrap with random stalls");
    req_mode = 2; resp_mode = 2; ack_mode = 2; resp_delay = 1;
    req0 = req_total; base = rst_log.size();
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 3) applyStimulus(LIW'(26'h400 + (i - 1) * 3), 1'b1);
      else            applyStimulus(LIW'(26'h400 + i * 3), 1'b0);
    end
    wait_idle(3000);
    checkOutput("wrap_req_count", LW'(req_total - req0), LW'(15));
    checkOutput("wrap_restart_count", LW'(rst_log.size() - base), LW'(20));

    // Restart stall: second response must wait for the ack.
    $display("[TB] restart stall");
    req_mode = 1; resp_mode = 1; ack_mode = 0; resp_delay = 1;
    step();
    base = rst_log.size();
    applyStimulus(26'h500, 1'b0);
    applyStimulus(26'h510, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (restart_valid && mem_resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("stall_setup", LW'(seen), LW'(1));
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall_resp_ready", LW'(mem_resp_ready), LW'(0));
      checkOutput("stall_restart_addr", LW'(restart_addr), LW'(26'h500));
      checkOutput("stall_restart_fill", LW'(restart_is_fill), LW'(1));
      step();
      @(negedge clk);
    end
    step();
    ack_mode = 1;
    wait_idle(200);
    checkOutput("stall_restart_count", LW'(rst_log.size() - base), LW'(2));
    if (rst_log.size() > base + 1) begin
      checkOutput("stall_order_second", LW'(rst_log[base+1]), LW'({26'h510, 1'b1}));
    end

    // Reset mid-operation with three entries waiting, then a clean miss.
    $display("[TB] reset mid-operation");
    req_mode = 0;
    step();
    applyStimulus(26'h600, 1'b0);
    applyStimulus(26'h610, 1'b0);
    applyStimulus(26'h620, 1'b0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_enq_ready", LW'(enq_ready), LW'(1));
    checkOutput("mid_rst_mem_req_valid", LW'(mem_req_valid), LW'(0));
    checkOutput("mid_rst_mem_resp_ready", LW'(mem_resp_ready), LW'(0));
    checkOutput("mid_rst_restart_valid", LW'(restart_valid), LW'(0));
    checkOutput("mid_rst_restart_is_fill", LW'(restart_is_fill), LW'(0));
    req_mode = 1; resp_delay = 2;
    step();
    base = rst_log.size();
    applyStimulus(26'h700, 1'b0);
    wait_idle(200);
    checkOutput("post_rst_restart_count", LW'(rst_log.size() - base), LW'(1));
    if (rst_log.size() > base) begin
      checkOutput("post_rst_restart", LW'(rst_log[base]), LW'({26'h700, 1'b1}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
